// File: rtl/dram_pkg.sv
// Shared data-RAM definitions: funct3 load/store encodings (common with the RAM wrapper)
// and the port identifiers used for grant vectors and read-owner tracking.
package dram_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/dram_arb_pick.sv
// Two-way combinational pick returning a one-hot grant. prio_dbg selects which port
// wins a tie; the caller derives it from either the starvation count or round-robin state.
module dram_arb_pick
  import dram_pkg::*;
(
  input  logic       req_core,
  input  logic       req_dbg,
  input  logic       prio_dbg,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_core && (!req_dbg || !prio_dbg)) begin
      gnt[PORT_CORE] = 1'b1;
    end else if (req_dbg) begin
      gnt[PORT_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter (core LSU / debug-DMA) in front of the single-ported data RAM wrapper.
// Define DRAM_ARB_RR_EN for round-robin; otherwise fixed priority with a port 1 starvation guard.
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 32
) (
  input  logic          sclk,
  input  logic          rstn,
  input  logic          p0_req,
  input  logic          p0_wr,
  input  logic [2:0]    p0_op,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_wr,
  input  logic [2:0]    p1_op,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [2:0]    mem_op,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [3:0]    starve_cnt
);

  // Handshake: a port raises req with stable fields and holds them until gnt; gnt is
  // combinational in that same cycle and means the access is issued now (stores commit at
  // the next sclk edge, load data arrives on rvalid exactly one cycle later).

  logic [1:0] gnt;
  logic       prio_dbg;
  logic       rd_pend;
  logic       rd_owner;

  dram_arb_pick u_pick (
    .req_core (p0_req),
    .req_dbg  (p1_req),
    .prio_dbg (prio_dbg),
    .gnt      (gnt)
  );

`ifdef DRAM_ARB_RR_EN
  logic last_winner;

  // Reset to the debug port so the core wins the first tie.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      last_winner <= PORT_DBG;
    end else if (gnt != 2'b00) begin
      last_winner <= gnt[PORT_DBG];
    end
  end

  assign prio_dbg   = (last_winner == PORT_CORE);
  assign starve_cnt = 4'd0;
`else
  logic [3:0] starve_q;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= 4'd0;
    end else if (!p1_req || gnt[PORT_DBG]) begin
      starve_q <= 4'd0;
    end else if (starve_q != 4'(MAX_WAIT)) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  assign prio_dbg   = (starve_q == 4'(MAX_WAIT));
  assign starve_cnt = starve_q;
`endif

  assign p0_gnt = gnt[PORT_CORE];
  assign p1_gnt = gnt[PORT_DBG];

  always_comb begin
    mem_op    = p0_op;
    mem_addr  = p0_addr;
    mem_wdata = p0_wdata;
    if (gnt[PORT_DBG]) begin
      mem_op    = p1_op;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  assign mem_wr = (gnt[PORT_CORE] && p0_wr) || (gnt[PORT_DBG] && p1_wr);
  assign mem_rd = (gnt[PORT_CORE] && !p0_wr) || (gnt[PORT_DBG] && !p1_wr);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      rd_pend  <= 1'b0;
      rd_owner <= PORT_CORE;
    end else begin
      rd_pend <= mem_rd;
      if (mem_rd) begin
        rd_owner <= gnt[PORT_DBG];
      end
    end
  end

  // Read data is broadcast unmasked; only rvalid identifies the owner.
  assign p0_rvalid = rd_pend && (rd_owner == PORT_CORE);
  assign p1_rvalid = rd_pend && (rd_owner == PORT_DBG);
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: behavioural RAM wrapper plus a reference model of
// the arbitration rules and read return, driven by directed scenarios and random traffic.
module tb_dram_arbiter;
  import dram_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int AW       = 32;

  logic          sclk;
  logic          rstn;
  logic          p0_req, p0_wr, p1_req, p1_wr;
  logic [2:0]    p0_op, p1_op;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          mem_wr, mem_rd;
  logic [2:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [3:0]    starve_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  dram_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .sclk(sclk), .rstn(rstn),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_op(p0_op), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_op(p1_op), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  // ---------------- clock / reset ----------------
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // ---------------- RAM wrapper stand-in (256 bytes, little-endian) ----------------
  logic [7:0] ram [256];
  logic [7:0] env_a;

  function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [31:0] w);
    case (op)
      F3_LB:   return {{24{w[7]}}, w[7:0]};
      F3_LH:   return {{16{w[15]}}, w[15:0]};
      F3_LBU:  return {24'd0, w[7:0]};
      F3_LHU:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  initial mem_rdata = 32'd0;
  always @(posedge sclk) begin
    env_a = mem_addr[7:0];
    if (mem_wr) begin
      ram[env_a] <= mem_wdata[7:0];
      if (mem_op != F3_SB) ram[env_a + 8'd1] <= mem_wdata[15:8];
      if (mem_op == F3_SW) begin
        ram[env_a + 8'd2] <= mem_wdata[23:16];
        ram[env_a + 8'd3] <= mem_wdata[31:24];
      end
    end
    if (mem_rd) begin
      mem_rdata <= fmt_load(mem_op, {ram[env_a + 8'd3], ram[env_a + 8'd2],
                                     ram[env_a + 8'd1], ram[env_a]});
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_q[$];
  logic        exp_own_q[$];
  int          exp_wait;
  logic        exp_last;

  task automatic model_reset();
    exp_q.delete();
    exp_own_q.delete();
    exp_wait = 0;
    exp_last = 1'b1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ram[a + 8'(i)]     = w[8*i +: 8];
      ref_mem[a + 8'(i)] = w[8*i +: 8];
    end
  endtask

  // One bus cycle: called at negedge with inputs set; checks outputs, advances the model.
  task automatic run_cycle(input string tag, output logic g0, output logic g1);
    logic        e0, e1, ew, er, pend, own, ewr;
    logic [2:0]  eop;
    logic [AW-1:0] eaddr;
    logic [31:0] ewd, ed;
    logic [7:0]  a;
    #1;
`ifdef DRAM_ARB_RR_EN
    if (p0_req && p1_req) begin
      e1 = !exp_last;
      e0 = exp_last;
    end else begin
      e0 = p0_req;
      e1 = p1_req;
    end
`else
    e0 = p0_req && !(p1_req && exp_wait == MAX_WAIT);
    e1 = p1_req && !e0;
`endif
    ewr   = e1 ? p1_wr : p0_wr;
    eop   = e1 ? p1_op : p0_op;
    eaddr = e1 ? p1_addr : p0_addr;
    ewd   = e1 ? p1_wdata : p0_wdata;
    ew    = (e0 || e1) && ewr;
    er    = (e0 || e1) && !ewr;

    n_checks++;
    if ({p0_gnt, p1_gnt} !== {e0, e1}) begin
      n_fail++;
      $display("FAIL %s grant: got p0=%b p1=%b expected p0=%b p1=%b", tag, p0_gnt, p1_gnt, e0, e1);
    end
    n_checks++;
    if ({mem_wr, mem_rd} !== {ew, er}) begin
      n_fail++;
      $display("FAIL %s mem_wr/rd: got %b/%b expected %b/%b", tag, mem_wr, mem_rd, ew, er);
    end
    if (e0 || e1) begin
      n_checks++;
      if (mem_addr !== eaddr || mem_op !== eop || (ewr && mem_wdata !== ewd)) begin
        n_fail++;
        $display("FAIL %s mem fields: got addr=%h op=%0d wd=%h expected addr=%h op=%0d wd=%h",
                 tag, mem_addr, mem_op, mem_wdata, eaddr, eop, ewd);
      end
    end
    n_checks++;
`ifdef DRAM_ARB_RR_EN
    if (starve_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL %s starve_cnt: got %0d expected 0", tag, starve_cnt);
    end
`else
    if (starve_cnt !== 4'(exp_wait)) begin
      n_fail++;
      $display("FAIL %s starve_cnt: got %0d expected %0d", tag, starve_cnt, exp_wait);
    end
`endif
    pend = (exp_q.size() > 0);
    own  = 1'b0;
    ed   = 32'd0;
    if (pend) begin
      ed  = exp_q.pop_front();
      own = exp_own_q.pop_front();
    end
    n_checks++;
    if (p0_rvalid !== (pend && !own) || p1_rvalid !== (pend && own)) begin
      n_fail++;
      $display("FAIL %s rvalid: got p0=%b p1=%b expected p0=%b p1=%b",
               tag, p0_rvalid, p1_rvalid, pend && !own, pend && own);
    end
    if (pend) begin
      n_checks++;
      if (p0_rdata !== ed || p1_rdata !== ed) begin
        n_fail++;
        $display("FAIL %s rdata: got p0=%h p1=%h expected %h", tag, p0_rdata, p1_rdata, ed);
      end
    end

    a = eaddr[7:0];
    if (er) begin
      exp_q.push_back(fmt_load(eop, {ref_mem[a + 8'd3], ref_mem[a + 8'd2],
                                     ref_mem[a + 8'd1], ref_mem[a]}));
      exp_own_q.push_back(e1);
    end
    if (ew) begin
      ref_mem[a] = ewd[7:0];
      if (eop != F3_SB) ref_mem[a + 8'd1] = ewd[15:8];
      if (eop == F3_SW) begin
        ref_mem[a + 8'd2] = ewd[23:16];
        ref_mem[a + 8'd3] = ewd[31:24];
      end
    end
    if (p1_req && !e1) exp_wait = (exp_wait < MAX_WAIT) ? exp_wait + 1 : MAX_WAIT;
    else exp_wait = 0;
    if (e0 || e1) exp_last = e1;
    g0 = e0;
    g1 = e1;
    @(negedge sclk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_p0(input logic req, input logic wr, input logic [2:0] op,
                        input logic [AW-1:0] addr, input logic [31:0] wd);
    p0_req = req; p0_wr = wr; p0_op = op; p0_addr = addr; p0_wdata = wd;
  endtask

  task automatic set_p1(input logic req, input logic wr, input logic [2:0] op,
                        input logic [AW-1:0] addr, input logic [31:0] wd);
    p1_req = req; p1_wr = wr; p1_op = op; p1_addr = addr; p1_wdata = wd;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge sclk);
    model_reset();
    rstn = 1'b1;
  endtask

  task automatic gen_req(output logic wr, output logic [2:0] op,
                         output logic [AW-1:0] addr, output logic [31:0] wd);
    int k;
    logic [7:0] a;
    k  = $urandom_range(0, 7);
    wr = (k < 3);
    case (k)
      0: op = F3_SB;   1: op = F3_SH;   2: op = F3_SW;
      3: op = F3_LB;   4: op = F3_LH;   5: op = F3_LW;
      6: op = F3_LBU;  default: op = F3_LHU;
    endcase
    a = 8'($urandom_range(0, 255));
    if (op[1:0] == 2'b01) a[0] = 1'b0;
    if (op[1:0] == 2'b10) a[1:0] = 2'b00;
    addr = AW'(a);
    wd   = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    set_p0(1'b0, 1'b0, F3_LW, '0, '0);
    set_p1(1'b0, 1'b0, F3_LW, '0, '0);
    repeat (2) @(negedge sclk);
    #1;
    n_checks++;
    if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wr, mem_rd} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got gnt=%b%b rvalid=%b%b wr=%b rd=%b expected all 0",
               p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wr, mem_rd);
    end
    n_checks++;
    if (starve_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset starve_cnt: got %0d expected 0", starve_cnt);
    end
    @(negedge sclk);
    model_reset();
    rstn = 1'b1;
  endtask

  task automatic test_p0_load();
    logic g0, g1;
    preload(8'h10, 32'hDEADBEEF);
    set_p0(1'b1, 1'b0, F3_LW, 32'h10, '0);
    run_cycle("p0_lw_issue", g0, g1);
    p0_req = 1'b0;
    #1;
    n_checks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL p0_lw_data: got rvalid=%b/%b data=%h expected 1/0 deadbeef",
               p0_rvalid, p1_rvalid, p0_rdata);
    end
    run_cycle("p0_lw_ret", g0, g1);
  endtask

  task automatic test_both_loads();
    logic g0, g1;
    preload(8'h20, 32'h11112222);
    preload(8'h24, 32'h83334444);
    set_p0(1'b1, 1'b0, F3_LW, 32'h20, '0);
    set_p1(1'b1, 1'b0, F3_LH, 32'h26, '0);
    run_cycle("both_tie", g0, g1);
    if (g0) p0_req = 1'b0;
    if (g1) p1_req = 1'b0;
    run_cycle("both_second", g0, g1);
    if (g0) p0_req = 1'b0;
    if (g1) p1_req = 1'b0;
    run_cycle("both_drain", g0, g1);
  endtask

`ifndef DRAM_ARB_RR_EN
  task automatic test_starvation();
    logic g0, g1;
    apply_reset();
    set_p0(1'b1, 1'b0, F3_LW, 32'h40, '0);
    set_p1(1'b1, 1'b0, F3_LW, 32'h44, '0);
    for (int i = 0; i <= MAX_WAIT; i++) begin
      #1;
      n_checks++;
      if (p1_gnt !== (i == MAX_WAIT) || starve_cnt !== 4'(i)) begin
        n_fail++;
        $display("FAIL starve_step%0d: got p1_gnt=%b cnt=%0d expected %b %0d",
                 i, p1_gnt, starve_cnt, i == MAX_WAIT, i);
      end
      run_cycle("starve", g0, g1);
    end
    #1;
    n_checks++;
    if (starve_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL starve_clear: got %0d expected 0", starve_cnt);
    end
    set_p0(1'b0, 1'b0, F3_LW, '0, '0);
    set_p1(1'b0, 1'b0, F3_LW, '0, '0);
    run_cycle("starve_drain", g0, g1);
  endtask
`endif

  task automatic test_store_then_load();
    logic g0, g1;
    set_p1(1'b1, 1'b1, F3_SB, 32'h3, 32'h123456A5);
    run_cycle("sb_issue", g0, g1);
    p1_req = 1'b0;
    set_p0(1'b1, 1'b0, F3_LBU, 32'h3, '0);
    run_cycle("lbu_issue", g0, g1);
    p0_req = 1'b0;
    #1;
    n_checks++;
    if (p0_rdata !== 32'h000000A5 || p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_lbu: got data=%h rvalid=%b/%b expected 000000a5 1/0",
               p0_rdata, p0_rvalid, p1_rvalid);
    end
    run_cycle("lbu_ret", g0, g1);
  endtask

  task automatic test_reset_mid_read();
    logic g0, g1;
    set_p0(1'b1, 1'b0, F3_LW, 32'h10, '0);
    set_p1(1'b1, 1'b0, F3_LW, 32'h14, '0);
    run_cycle("rst_pre0", g0, g1);
    run_cycle("rst_pre1", g0, g1);
    p0_req = 1'b0;
    p1_req = 1'b0;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || starve_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid_read: got rvalid=%b/%b cnt=%0d expected 0/0 0",
               p0_rvalid, p1_rvalid, starve_cnt);
    end
    @(negedge sclk);
    model_reset();
    rstn = 1'b1;
    run_cycle("rst_after", g0, g1);
  endtask

`ifdef DRAM_ARB_RR_EN
  task automatic test_round_robin();
    logic g0, g1;
    apply_reset();
    set_p0(1'b1, 1'b0, F3_LW, 32'h10, '0);
    set_p1(1'b1, 1'b1, F3_SW, 32'h80, 32'hCAFEF00D);
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (p0_gnt !== (i % 2 == 0) || p1_gnt !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_step%0d: got p0=%b p1=%b expected p0=%b p1=%b",
                 i, p0_gnt, p1_gnt, i % 2 == 0, i % 2 == 1);
      end
      run_cycle("rr", g0, g1);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    run_cycle("rr_drain", g0, g1);
  endtask
`endif

  task automatic test_random();
    logic g0, g1, wr;
    logic [2:0] op;
    logic [AW-1:0] addr;
    logic [31:0] wd;
    for (int i = 0; i < 600; i++) begin
      if (!p0_req && $urandom_range(0, 3) != 0) begin
        gen_req(wr, op, addr, wd);
        set_p0(1'b1, wr, op, addr, wd);
      end
      if (!p1_req && $urandom_range(0, 1) != 0) begin
        gen_req(wr, op, addr, wd);
        set_p1(1'b1, wr, op, addr, wd);
      end
      run_cycle("random", g0, g1);
      if (g0) p0_req = 1'b0;
      if (g1) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    run_cycle("random_drain", g0, g1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    model_reset();
    test_reset();
    test_p0_load();
    test_both_loads();
`ifndef DRAM_ARB_RR_EN
    test_starvation();
`endif
    test_store_then_load();
    test_reset_mid_read();
`ifdef DRAM_ARB_RR_EN
    test_round_robin();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
